// File: rtl/vdp_vram_pkg.sv
// Shared types and constants for the VDP VRAM slot scheduler.
// Owner codes double as the debug value on vram_owner.
package vdp_vram_pkg;

    typedef enum logic [2:0] {
        OwnNone    = 3'd0,
        OwnScreen  = 3'd1,
        OwnSprite  = 3'd2,
        OwnCpu     = 3'd3,
        OwnCmd     = 3'd4,
        OwnRefresh = 3'd5
    } owner_e;

    typedef enum logic [1:0] {
        ClsFree,
        ClsRefresh,
        ClsScreen,
        ClsSprite
    } slot_class_e;

    localparam int unsigned DEF_SCREEN_SLOT_START = 16;
    localparam int unsigned DEF_SCREEN_SLOT_END   = 271;
    localparam int unsigned DEF_SPRITE_SLOT_START = 272;
    localparam int unsigned DEF_SPRITE_SLOT_END   = 303;
    localparam int unsigned DEF_REFRESH_SLOT_A    = 0;
    localparam int unsigned DEF_REFRESH_SLOT_B    = 171;
    localparam int unsigned DEF_STARVE_LIMIT      = 3;

    localparam logic [2:0] PHASE_ISSUE   = 3'd1;
    localparam logic [2:0] PHASE_CAPTURE = 3'd6;
    localparam logic [2:0] PHASE_ACK     = 3'd7;

    function automatic logic is_access(owner_e o);
        return o inside {OwnScreen, OwnSprite, OwnCpu, OwnCmd};
    endfunction

endpackage

// File: rtl/vdp_vram_slot_map.sv
// Combinational slot classifier: decides which fixed user, if any, owns a slot.
// Earlier tests take priority, so refresh wins over the screen window.
module vdp_vram_slot_map
    import vdp_vram_pkg::*;
#(
    parameter int unsigned SCREEN_SLOT_START = DEF_SCREEN_SLOT_START,
    parameter int unsigned SCREEN_SLOT_END   = DEF_SCREEN_SLOT_END,
    parameter int unsigned SPRITE_SLOT_START = DEF_SPRITE_SLOT_START,
    parameter int unsigned SPRITE_SLOT_END   = DEF_SPRITE_SLOT_END,
    parameter int unsigned REFRESH_SLOT_A    = DEF_REFRESH_SLOT_A,
    parameter int unsigned REFRESH_SLOT_B    = DEF_REFRESH_SLOT_B
) (
    input  logic [8:0]  slot,
    input  logic        act,
    input  logic        screen_v_active,
    input  logic        reg_sprite_disable,
    output slot_class_e slot_class
);

    logic [31:0] slot_w;
    assign slot_w = 32'(slot);

    always_comb begin
        slot_class = ClsFree;
        if (slot_w == REFRESH_SLOT_A || slot_w == REFRESH_SLOT_B) begin
            slot_class = ClsRefresh;
        end else if (act && slot_w >= SCREEN_SLOT_START && slot_w <= SCREEN_SLOT_END &&
                     slot[1:0] != 2'd3) begin
            slot_class = ClsScreen;
        end else if (screen_v_active && !reg_sprite_disable &&
                     slot_w >= SPRITE_SLOT_START && slot_w <= SPRITE_SLOT_END) begin
            slot_class = ClsSprite;
        end
    end

endmodule

// File: rtl/vdp_vram_slot_scheduler.sv
// Time-slot arbiter for the single VRAM port: 342 slots of 8 clocks per line,
// each owned by screen, sprite, refresh, CPU or command engine.
module vdp_vram_slot_scheduler
    import vdp_vram_pkg::*;
#(
    parameter int unsigned SCREEN_SLOT_START = DEF_SCREEN_SLOT_START,
    parameter int unsigned SCREEN_SLOT_END   = DEF_SCREEN_SLOT_END,
    parameter int unsigned SPRITE_SLOT_START = DEF_SPRITE_SLOT_START,
    parameter int unsigned SPRITE_SLOT_END   = DEF_SPRITE_SLOT_END,
    parameter int unsigned REFRESH_SLOT_A    = DEF_REFRESH_SLOT_A,
    parameter int unsigned REFRESH_SLOT_B    = DEF_REFRESH_SLOT_B,
    parameter int unsigned STARVE_LIMIT      = DEF_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] h_count,
    input  logic        screen_v_active,
    input  logic        reg_display_on,
    input  logic        reg_sprite_disable,
    input  logic [16:0] screen_address,
    input  logic [16:0] sprite_address,
    output logic [7:0]  fetch_rdata,
    output logic        screen_rdata_en,
    output logic        sprite_rdata_en,
    input  logic        cpu_req,
    input  logic        cpu_write,
    input  logic [16:0] cpu_address,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        cmd_req,
    input  logic        cmd_write,
    input  logic [16:0] cmd_address,
    input  logic [7:0]  cmd_wdata,
    output logic        cmd_ack,
    output logic [7:0]  cmd_rdata,
    output logic        vram_valid,
    output logic        vram_write,
    output logic [16:0] vram_address,
    output logic [7:0]  vram_wdata,
    output logic        vram_refresh,
    input  logic [7:0]  vram_rdata,
    output logic [2:0]  vram_owner
);

    logic [2:0]  phase;
    logic [2:0]  next_phase;
    logic [8:0]  slot;
    logic        act;
    slot_class_e slot_class;
    owner_e      grant;
    owner_e      owner;
    logic [1:0]  starve_cnt;
    logic        starved;
    logic [16:0] sel_address;
    logic        sel_write;
    logic [7:0]  sel_wdata;

    assign phase      = h_count[2:0];
    assign next_phase = phase + 3'd1;
    assign slot       = h_count[11:3];
    assign act        = screen_v_active & reg_display_on;
    assign starved    = 32'(starve_cnt) >= STARVE_LIMIT;
    assign vram_owner = owner;

    vdp_vram_slot_map #(
        .SCREEN_SLOT_START (SCREEN_SLOT_START),
        .SCREEN_SLOT_END   (SCREEN_SLOT_END),
        .SPRITE_SLOT_START (SPRITE_SLOT_START),
        .SPRITE_SLOT_END   (SPRITE_SLOT_END),
        .REFRESH_SLOT_A    (REFRESH_SLOT_A),
        .REFRESH_SLOT_B    (REFRESH_SLOT_B)
    ) u_slot_map (
        .slot               (slot),
        .act                (act),
        .screen_v_active    (screen_v_active),
        .reg_sprite_disable (reg_sprite_disable),
        .slot_class         (slot_class)
    );

    always_comb begin
        grant = OwnNone;
        unique case (slot_class)
            ClsRefresh: grant = OwnRefresh;
            ClsScreen:  grant = OwnScreen;
            ClsSprite:  grant = OwnSprite;
            ClsFree: begin
                if (cmd_req && starved) begin
                    grant = OwnCmd;
                end else if (cpu_req) begin
                    grant = OwnCpu;
                end else if (cmd_req) begin
                    grant = OwnCmd;
                end
            end
        endcase
    end

    always_comb begin
        sel_address = '0;
        sel_write   = 1'b0;
        sel_wdata   = '0;
        unique case (grant)
            OwnScreen: sel_address = screen_address;
            OwnSprite: sel_address = sprite_address;
            OwnCpu: begin
                sel_address = cpu_address;
                sel_write   = cpu_write;
                sel_wdata   = cpu_wdata;
            end
            OwnCmd: begin
                sel_address = cmd_address;
                sel_write   = cmd_write;
                sel_wdata   = cmd_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner           <= OwnNone;
            starve_cnt      <= 2'd0;
            vram_valid      <= 1'b0;
            vram_refresh    <= 1'b0;
            vram_write      <= 1'b0;
            vram_address    <= '0;
            vram_wdata      <= '0;
            cpu_ack         <= 1'b0;
            cmd_ack         <= 1'b0;
            screen_rdata_en <= 1'b0;
            sprite_rdata_en <= 1'b0;
            cpu_rdata       <= '0;
            cmd_rdata       <= '0;
            fetch_rdata     <= '0;
        end else begin
            vram_valid      <= 1'b0;
            vram_refresh    <= 1'b0;
            cpu_ack         <= 1'b0;
            cmd_ack         <= 1'b0;
            screen_rdata_en <= 1'b0;
            sprite_rdata_en <= 1'b0;

            // Grant and latch on the edge leaving phase 0.
            if (next_phase == PHASE_ISSUE) begin
                owner        <= grant;
                vram_valid   <= is_access(grant);
                vram_refresh <= (grant == OwnRefresh);
                vram_address <= sel_address;
                vram_write   <= sel_write;
                vram_wdata   <= sel_wdata;
                if (grant == OwnCmd) begin
                    starve_cnt <= 2'd0;
                end else if (grant == OwnCpu && cmd_req && starve_cnt != 2'd3) begin
                    starve_cnt <= starve_cnt + 2'd1;
                end
            end

            // Data sampled at the end of phase 6 is presented with the phase-7 pulse.
            if (phase == PHASE_CAPTURE && next_phase == PHASE_ACK) begin
                unique case (owner)
                    OwnScreen: begin
                        fetch_rdata     <= vram_rdata;
                        screen_rdata_en <= 1'b1;
                    end
                    OwnSprite: begin
                        fetch_rdata     <= vram_rdata;
                        sprite_rdata_en <= 1'b1;
                    end
                    OwnCpu: begin
                        if (!vram_write) cpu_rdata <= vram_rdata;
                        cpu_ack <= 1'b1;
                    end
                    OwnCmd: begin
                        if (!vram_write) cmd_rdata <= vram_rdata;
                        cmd_ack <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vdp_vram_slot_scheduler.sv
// Bench for vdp_vram_slot_scheduler: slot-level behavioural model checked every cycle,
// directed line scenarios with literal counts, then randomized traffic.
module tb_vdp_vram_slot_scheduler;

    localparam int LINE = 2736;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] h_count = '0;
    logic        screen_v_active = 1'b0;
    logic        reg_display_on = 1'b0;
    logic        reg_sprite_disable = 1'b0;
    logic [16:0] screen_address = '0;
    logic [16:0] sprite_address = '0;
    logic [7:0]  fetch_rdata;
    logic        screen_rdata_en;
    logic        sprite_rdata_en;
    logic        cpu_req = 1'b0;
    logic        cpu_write = 1'b0;
    logic [16:0] cpu_address = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cmd_req = 1'b0;
    logic        cmd_write = 1'b0;
    logic [16:0] cmd_address = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        cmd_ack;
    logic [7:0]  cmd_rdata;
    logic        vram_valid;
    logic        vram_write;
    logic [16:0] vram_address;
    logic [7:0]  vram_wdata;
    logic        vram_refresh;
    logic [7:0]  vram_rdata = '0;
    logic [2:0]  vram_owner;

    always #5 clk = ~clk;

    vdp_vram_slot_scheduler dut (
        .clk                (clk),
        .reset              (reset),
        .h_count            (h_count),
        .screen_v_active    (screen_v_active),
        .reg_display_on     (reg_display_on),
        .reg_sprite_disable (reg_sprite_disable),
        .screen_address     (screen_address),
        .sprite_address     (sprite_address),
        .fetch_rdata        (fetch_rdata),
        .screen_rdata_en    (screen_rdata_en),
        .sprite_rdata_en    (sprite_rdata_en),
        .cpu_req            (cpu_req),
        .cpu_write          (cpu_write),
        .cpu_address        (cpu_address),
        .cpu_wdata          (cpu_wdata),
        .cpu_ack            (cpu_ack),
        .cpu_rdata          (cpu_rdata),
        .cmd_req            (cmd_req),
        .cmd_write          (cmd_write),
        .cmd_address        (cmd_address),
        .cmd_wdata          (cmd_wdata),
        .cmd_ack            (cmd_ack),
        .cmd_rdata          (cmd_rdata),
        .vram_valid         (vram_valid),
        .vram_write         (vram_write),
        .vram_address       (vram_address),
        .vram_wdata         (vram_wdata),
        .vram_refresh       (vram_refresh),
        .vram_rdata         (vram_rdata),
        .vram_owner         (vram_owner)
    );

    int tests = 0;
    int fails = 0;

    // Slot-level model: who owns the current slot and what was latched for it.
    int          m_owner;
    int          m_starve;
    logic [16:0] m_addr;
    logic        m_write;
    logic [7:0]  m_wdata;
    logic [7:0]  m_cpu_rd;
    logic [7:0]  m_cmd_rd;
    logic [7:0]  m_fetch_rd;

    bit          chk_en = 1'b0;
    bit          hold_h = 1'b1;
    bit          cpu_rand = 1'b0;
    bit          cmd_rand = 1'b0;
    bit          env_rand = 1'b0;
    bit          jump_en = 1'b0;
    bit          rd_fixed_en = 1'b1;
    logic [7:0]  rd_fixed = 8'h3C;

    int cnt_cpu_ack, cnt_cmd_ack, cnt_screen, cnt_sprite;
    int refresh_h[$];
    int grants[$];

    int          cmp_p;
    bit          cmp_acc;
    logic [5:0]  cmp_exp;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (h_count=%0d, t=%0t)",
                     name, actual, expected, h_count, $time);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, 32'({vram_valid, vram_write, vram_refresh, cpu_ack, cmd_ack,
                                   screen_rdata_en, sprite_rdata_en, vram_owner}), 32'd0);
        check({name, "_addr"}, 32'(vram_address), 32'd0);
        check({name, "_data"}, {vram_wdata, cpu_rdata, cmd_rdata, fetch_rdata}, 32'd0);
    endtask

    task automatic model_reset();
        m_owner    = 0;
        m_starve   = 0;
        m_addr     = '0;
        m_write    = 1'b0;
        m_wdata    = '0;
        m_cpu_rd   = '0;
        m_cmd_rd   = '0;
        m_fetch_rd = '0;
    endtask

    // Owner code for a fixed slot, 0 when the slot is up for arbitration.
    function automatic int classify(int slot, bit act, bit sva, bit sdis);
        if (slot == 0 || slot == 171) return 5;
        if (act && slot >= 16 && slot <= 271 && (slot % 4) != 3) return 1;
        if (sva && !sdis && slot >= 272 && slot <= 303) return 2;
        return 0;
    endfunction

    task automatic clear_counts();
        cnt_cpu_ack = 0;
        cnt_cmd_ack = 0;
        cnt_screen  = 0;
        cnt_sprite  = 0;
        refresh_h.delete();
        grants.delete();
    endtask

    // One clock: update the model with the values present at the edge, then drive new inputs.
    task automatic cycle();
        int p, slot, own;
        bit cpu_done, cmd_done;
        @(posedge clk);
        #2;
        p = int'(h_count[2:0]);
        slot = int'(h_count[11:3]);
        cpu_done = 1'b0;
        cmd_done = 1'b0;
        if (reset) begin
            model_reset();
        end else begin
            cpu_done = (p == 7 && m_owner == 3);
            cmd_done = (p == 7 && m_owner == 4);
            if (p == 0) begin
                own = classify(slot, screen_v_active && reg_display_on, screen_v_active,
                               reg_sprite_disable);
                if (own == 0) begin
                    if (cmd_req && m_starve >= 3) own = 4;
                    else if (cpu_req) own = 3;
                    else if (cmd_req) own = 4;
                    if (own == 3 && cmd_req && m_starve < 3) m_starve++;
                    if (own == 4) m_starve = 0;
                end
                m_owner = own;
                case (own)
                    1: begin m_addr = screen_address; m_write = 1'b0; end
                    2: begin m_addr = sprite_address; m_write = 1'b0; end
                    3: begin m_addr = cpu_address; m_write = cpu_write; m_wdata = cpu_wdata; end
                    4: begin m_addr = cmd_address; m_write = cmd_write; m_wdata = cmd_wdata; end
                    default: ;
                endcase
            end
            if (p == 6) begin
                if (m_owner == 1 || m_owner == 2) m_fetch_rd = vram_rdata;
                if (m_owner == 3 && !m_write) m_cpu_rd = vram_rdata;
                if (m_owner == 4 && !m_write) m_cmd_rd = vram_rdata;
            end
        end
        if (cpu_rand && (cpu_done || (m_owner != 3 && $urandom_range(7) == 0))) begin
            cpu_req     = ($urandom_range(3) != 0);
            cpu_write   = 1'($urandom_range(1));
            cpu_address = 17'($urandom);
            cpu_wdata   = 8'($urandom);
        end
        if (cmd_rand && (cmd_done || (m_owner != 4 && $urandom_range(7) == 0))) begin
            cmd_req     = ($urandom_range(3) != 0);
            cmd_write   = 1'($urandom_range(1));
            cmd_address = 17'($urandom);
            cmd_wdata   = 8'($urandom);
        end
        if (env_rand && $urandom_range(255) == 0) begin
            screen_v_active    = 1'($urandom_range(1));
            reg_display_on     = 1'($urandom_range(1));
            reg_sprite_disable = 1'($urandom_range(1));
        end
        screen_address = 17'($urandom);
        sprite_address = 17'($urandom);
        if (!hold_h) begin
            if (jump_en && p == 7 && $urandom_range(199) == 0)
                h_count = 12'(8 * $urandom_range(341));
            else
                h_count = (h_count == 12'(LINE - 1)) ? 12'd0 : h_count + 12'd1;
        end
        vram_rdata = rd_fixed_en ? rd_fixed : 8'($urandom);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    // Single compare process: DUT outputs against the model on every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_p   = int'(h_count[2:0]);
            cmp_acc = (m_owner >= 1 && m_owner <= 4);
            cmp_exp = {cmp_p == 1 && cmp_acc, cmp_p == 1 && m_owner == 5,
                       cmp_p == 7 && m_owner == 3, cmp_p == 7 && m_owner == 4,
                       cmp_p == 7 && m_owner == 1, cmp_p == 7 && m_owner == 2};
            check("strobes", 32'({vram_valid, vram_refresh, cpu_ack, cmd_ack, screen_rdata_en,
                                  sprite_rdata_en}), 32'(cmp_exp));
            check("owner", 32'(vram_owner), 32'(m_owner));
            check("rdata", 32'({cpu_rdata, cmd_rdata, fetch_rdata}),
                  32'({m_cpu_rd, m_cmd_rd, m_fetch_rd}));
            if (cmp_exp[5]) begin
                check("access", 32'({vram_write, vram_address}), 32'({m_write, m_addr}));
                if (m_write) check("wdata", 32'(vram_wdata), 32'(m_wdata));
            end
            if (cpu_ack) cnt_cpu_ack++;
            if (cmd_ack) cnt_cmd_ack++;
            if (screen_rdata_en) cnt_screen++;
            if (sprite_rdata_en) cnt_sprite++;
            if (vram_refresh) refresh_h.push_back(int'(h_count));
            if (vram_valid && (vram_owner == 3'd3 || vram_owner == 3'd4))
                grants.push_back(int'(vram_owner));
        end
    end

    initial begin
        model_reset();
        clear_counts();
        cycle();
        chk_en = 1'b1;
        cycles(2);
        at_neg();
        check_all_zero("reset_state");

        // Idle blanking line with the CPU reading continuously.
        cycle();
        reset = 1'b0;
        hold_h = 1'b0;
        cpu_req = 1'b1;
        cpu_write = 1'b0;
        cpu_address = 17'h01234;
        clear_counts();
        cycles(LINE);
        check("idle_cpu_acks", 32'(cnt_cpu_ack), 32'd340);
        check("idle_refresh_cnt", 32'(refresh_h.size()), 32'd2);
        if (refresh_h.size() == 2) begin
            check("refresh_h0", 32'(refresh_h[0]), 32'd1);
            check("refresh_h1", 32'(refresh_h[1]), 32'd1369);
        end

        // Active display line with sprites.
        screen_v_active = 1'b1;
        reg_display_on = 1'b1;
        clear_counts();
        cycles(LINE);
        check("active_screen", 32'(cnt_screen), 32'd192);
        check("active_sprite", 32'(cnt_sprite), 32'd32);
        check("active_cpu", 32'(cnt_cpu_ack), 32'd116);

        // Sprites disabled: their slots fall to the CPU.
        reg_sprite_disable = 1'b1;
        clear_counts();
        cycles(LINE);
        check("nospr_screen", 32'(cnt_screen), 32'd192);
        check("nospr_sprite", 32'(cnt_sprite), 32'd0);
        check("nospr_cpu", 32'(cnt_cpu_ack), 32'd148);

        // CPU and command engine both requesting on a blanking line.
        screen_v_active = 1'b0;
        reg_display_on = 1'b0;
        reg_sprite_disable = 1'b0;
        cmd_req = 1'b1;
        cmd_write = 1'b0;
        cmd_address = 17'h10000;
        clear_counts();
        cycles(LINE);
        check("share_cmd", 32'(cnt_cmd_ack), 32'd85);
        check("share_cpu", 32'(cnt_cpu_ack), 32'd255);
        check("share_grants", 32'(grants.size()), 32'd340);
        for (int i = 0; i < 8 && i < grants.size(); i++)
            check("share_pattern", 32'(grants[i]), (i % 4 == 3) ? 32'd4 : 32'd3);

        // Command read returning A5; CPU read data must stay at its last value.
        cpu_req = 1'b0;
        cmd_address = 17'h0ABCD;
        rd_fixed = 8'hA5;
        cycles(15);
        at_neg();
        check("cmd_rd_ack", 32'(cmd_ack), 32'd1);
        check("cmd_rd_data", 32'(cmd_rdata), 32'hA5);
        check("cpu_rd_hold", 32'(cpu_rdata), 32'h3C);

        // Back-to-back CPU accesses with a new address issued on the ack edge.
        cycle();
        cmd_req = 1'b0;
        cpu_req = 1'b1;
        cpu_write = 1'b0;
        cpu_address = 17'h000A1;
        cycle();
        at_neg();
        check("b2b_first_addr", 32'({vram_valid, vram_address}), 32'({1'b1, 17'h000A1}));
        cycles(6);
        at_neg();
        check("b2b_first_ack", 32'(cpu_ack), 32'd1);
        cycle();
        cpu_address = 17'h000A2;
        cycle();
        at_neg();
        check("b2b_second_addr", 32'({vram_valid, vram_address}), 32'({1'b1, 17'h000A2}));

        // Address changed mid-slot must not disturb the access in flight.
        cycles(2);
        cpu_address = 17'h0BEEF;
        cycle();
        at_neg();
        check("late_change_addr", 32'(vram_address), 32'h000A2);

        // Reset at phase 4 of a CPU slot.
        cycles(8);
        check("pre_reset_phase", 32'(h_count[2:0]), 32'd4);
        reset = 1'b1;
        model_reset();
        #1;
        check_all_zero("reset_mid_slot");
        cnt_cpu_ack = 0;
        cycles(4);
        reset = 1'b0;
        check("reset_no_ack", 32'(cnt_cpu_ack), 32'd0);
        cycle();
        at_neg();
        check("post_reset_grant", 32'({vram_valid, vram_owner, vram_address}),
              32'({1'b1, 3'd3, 17'h0BEEF}));

        // Randomized traffic, register changes and slot-aligned realignments.
        cpu_rand = 1'b1;
        cmd_rand = 1'b1;
        env_rand = 1'b1;
        jump_en = 1'b1;
        rd_fixed_en = 1'b0;
        cycles(4 * LINE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
